// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared definitions for the up/down sweep controller.
//   DEFAULT_WIDTH : default counter width in bits
//   NSWEEP_W      : width of the round-trip count input
//   state_e       : sweep FSM state encoding (IDLE, UP, DOWN)
package updown_sweep_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 5;
    localparam int NSWEEP_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/updown_core.sv
// Loadable up/down counter register driven by the sweep FSM.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset, clears count to 0
//   load     : load load_val this edge (wins over en)
//   load_val : value to load
//   en       : step the counter by one this edge
//   up       : step direction when en is set (1 = +1, 0 = -1)
//   count    : registered counter value
module updown_core #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller: runs a counter lo->hi->lo for nsweep round trips.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   start  : begin a run (sampled in IDLE only; abort wins)
//   abort  : end any run immediately, no done/turn at that edge
//   lo, hi : sweep limits, latched on accepted start (requires lo < hi)
//   nsweep : round trips, latched on accepted start (requires != 0)
//   count  : registered counter value
//   dir    : 1 = counting up, 0 = counting down
//   busy   : high whenever not IDLE
//   turn   : one-cycle pulse on each direction reversal
//   done   : one-cycle pulse on normal completion
//   err    : one-cycle pulse on a rejected start
module updown_sweep_ctrl
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    input  logic [NSWEEP_W-1:0] nsweep,
    output logic [WIDTH-1:0]    count,
    output logic                dir,
    output logic                busy,
    output logic                turn,
    output logic                done,
    output logic                err
);

    state_e              state_q, state_d;
    logic                dir_q, dir_d;
    logic                turn_q, turn_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [NSWEEP_W-1:0] rem_q, rem_d;     // round trips still to finish

    logic                ld;
    logic [WIDTH-1:0]    ld_val;
    logic                cnt_en;
    logic                cnt_up;

    updown_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .count    (count)
    );

    // Limits are reversed by loading the neighbour value directly, so the
    // counter never steps past hi or below lo and cannot wrap.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        turn_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rem_d   = rem_q;
        ld      = 1'b0;
        ld_val  = count;
        cnt_en  = 1'b0;
        cnt_up  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (abort) begin
                    // abort masks start entirely, including the err check
                    state_d = IDLE;
                end else if (start) begin
                    if ((lo < hi) && (nsweep != '0)) begin
                        lo_d    = lo;
                        hi_d    = hi;
                        rem_d   = nsweep;
                        ld      = 1'b1;
                        ld_val  = lo;
                        dir_d   = 1'b1;
                        state_d = UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            UP: begin
                if (abort) begin
                    dir_d   = 1'b1;
                    state_d = IDLE;
                end else if (count >= hi_q) begin
                    ld      = 1'b1;
                    ld_val  = hi_q - WIDTH'(1);
                    dir_d   = 1'b0;
                    turn_d  = 1'b1;
                    state_d = DOWN;
                end else begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b1;
                end
            end

            DOWN: begin
                if (abort) begin
                    dir_d   = 1'b1;
                    state_d = IDLE;
                end else if (count <= lo_q) begin
                    dir_d = 1'b1;
                    if (rem_q > NSWEEP_W'(1)) begin
                        rem_d   = rem_q - NSWEEP_W'(1);
                        ld      = 1'b1;
                        ld_val  = lo_q + WIDTH'(1);
                        turn_d  = 1'b1;
                        state_d = UP;
                    end else begin
                        // count already sits at lo; simply hold it
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b0;
                end
            end

            default: begin
                dir_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b1;
            turn_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
        end
    end

    assign dir  = dir_q;
    assign busy = (state_q != IDLE);
    assign turn = turn_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl. Expected values come from a
// closed-form description of a run: the busy-cycle index k maps to a
// triangle-wave position between lo and hi.
module tb_updown_sweep_ctrl;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] lo = '0;
    logic [W-1:0] hi = '0;
    logic [3:0]   nsweep = '0;
    logic [W-1:0] count;
    logic         dir, busy, turn, done, err;

    int total = 0;
    int bad   = 0;
    int mcount = 0;   // model: count value expected while idle

    always #5 clk = ~clk;

    updown_sweep_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .lo     (lo),
        .hi     (hi),
        .nsweep (nsweep),
        .count  (count),
        .dir    (dir),
        .busy   (busy),
        .turn   (turn),
        .done   (done),
        .err    (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input int d, input int b,
                             input int t, input int dn, input int e);
        chk($sformatf("%s.count", tag), 32'(count), c);
        chk($sformatf("%s.dir",   tag), 32'(dir),   d);
        chk($sformatf("%s.busy",  tag), 32'(busy),  b);
        chk($sformatf("%s.turn",  tag), 32'(turn),  t);
        chk($sformatf("%s.done",  tag), 32'(done),  dn);
        chk($sformatf("%s.err",   tag), 32'(err),   e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count value in busy cycle k of a run: a triangle wave of period 2*(hi-lo).
    function automatic int pos(input int l, input int h, input int k);
        int d = h - l;
        int p = k % (2 * d);
        return (p <= d) ? l + p : l + 2 * d - p;
    endfunction

    function automatic int exp_dir(input int l, input int h, input int k);
        if (k == 0) return 1;
        return (pos(l, h, k) > pos(l, h, k - 1)) ? 1 : 0;
    endfunction

    // A turn is flagged in the cycle where the step direction first differs.
    function automatic int exp_turn(input int l, input int h, input int k);
        if (k < 2) return 0;
        return ((pos(l, h, k) > pos(l, h, k - 1)) != (pos(l, h, k - 1) > pos(l, h, k - 2))) ? 1 : 0;
    endfunction

    // One accepted run; abort_k < 0 means run to completion, otherwise abort
    // is raised during busy cycle abort_k. Inputs are scrambled while busy.
    task automatic do_run(input string tag, input int l, input int h, input int n, input int abort_k);
        int len = n * 2 * (h - l) + 1;
        int nturn = 0;
        int nbusy = 0;
        bit aborted = 1'b0;
        lo = W'(l); hi = W'(h); nsweep = 4'(n); start = 1'b1; abort = 1'b0;
        step();
        for (int k = 0; k < len; k++) begin
            check_all(tag, pos(l, h, k), exp_dir(l, h, k), 1, exp_turn(l, h, k), 0, 0);
            nturn += int'(turn);
            nbusy += int'(busy);
            start  = 1'($urandom_range(0, 1));
            lo     = W'($urandom);
            hi     = W'($urandom);
            nsweep = 4'($urandom);
            abort  = (k == abort_k);
            step();
            if (k == abort_k) begin
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0; abort = 1'b0;
        if (aborted) begin
            mcount = pos(l, h, abort_k);
            check_all({tag, ".abort"}, mcount, 1, 0, 0, 0, 0);
        end else begin
            mcount = l;
            check_all({tag, ".end"}, mcount, 1, 0, 0, 1, 0);
            chk({tag, ".turns"}, nturn, 2 * n - 1);
            chk({tag, ".busylen"}, nbusy, len);
        end
        step();
        check_all({tag, ".idle"}, mcount, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reject(input string tag, input int l, input int h, input int n);
        lo = W'(l); hi = W'(h); nsweep = 4'(n); start = 1'b1; abort = 1'b0;
        step();
        start = 1'b0;
        check_all(tag, mcount, 1, 0, 0, 0, 1);
        step();
        check_all({tag, ".after"}, mcount, 1, 0, 0, 0, 0);
    endtask

    initial begin
        int l, h, n, len, ak;

        // reset state
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 0, 1, 0, 0, 0, 0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("post_reset", 0, 1, 0, 0, 0, 0);
        end

        // basic run, rejects, full range
        do_run("basic", 2, 4, 1, -1);
        do_reject("rej_eq", 5, 5, 1);
        do_reject("rej_n0", 1, 9, 0);
        do_reject("rej_gt", 20, 3, 2);
        do_run("full", 0, 31, 2, -1);
        do_run("narrow", 7, 8, 3, -1);

        // abort mid-run at count=4 while rising
        do_run("abort", 1, 6, 1, 3);

        // start together with abort in IDLE: ignored, no err
        lo = 5'd1; hi = 5'd9; nsweep = 4'd1; start = 1'b1; abort = 1'b1;
        step();
        check_all("st_ab_ok", mcount, 1, 0, 0, 0, 0);
        lo = 5'd9; hi = 5'd1;
        step();
        check_all("st_ab_bad", mcount, 1, 0, 0, 0, 0);
        start = 1'b0; abort = 1'b0;
        step();
        check_all("st_ab_idle", mcount, 1, 0, 0, 0, 0);

        // asynchronous reset mid-run at count=3
        lo = 5'd0; hi = 5'd10; nsweep = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check_all("pre_rst", 3, 1, 1, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check_all("async_rst", 0, 1, 0, 0, 0, 0);
        step();
        @(negedge clk) reset = 1'b1;
        mcount = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_all("rst_idle", 0, 1, 0, 0, 0, 0);
        end
        do_run("after_rst", 3, 6, 2, -1);

        // randomized runs, some aborted, some rejected
        for (int it = 0; it < 12; it++) begin
            l = int'($urandom_range(0, 29));
            h = int'($urandom_range(l + 1, 31));
            n = int'($urandom_range(1, 3));
            len = n * 2 * (h - l) + 1;
            ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            do_run($sformatf("rnd%0d", it), l, h, n, ak);
            if ($urandom_range(0, 3) == 0) begin
                h = int'($urandom_range(0, 31));
                l = int'($urandom_range(h, 31));
                do_reject($sformatf("rndrej%0d", it), l, h, int'($urandom_range(0, 15)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 5, counter width in bits.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: input, 1 bit, asynchronous and active-low; low clears all state immediately.
REQ-004 Port start SHALL be: input, 1 bit, request to begin a sweep run; sampled only in IDLE.
REQ-005 Port abort SHALL be: input, 1 bit, terminates any run; priority over start.
REQ-006 Port lo SHALL be: input, WIDTH bits, lower sweep limit; latched on accepted start.
REQ-007 Port hi SHALL be: input, WIDTH bits, upper sweep limit; latched on accepted start.
REQ-008 Port nsweep SHALL be: input, 4 bits, number of round trips (lo->hi->lo); latched on accepted start.
REQ-009 Port count SHALL be: output, WIDTH bits, current counter value (registered).
REQ-010 Port dir SHALL be: output, 1 bit, current direction: 1 = up, 0 = down.
REQ-011 Port busy SHALL be: output, 1 bit, high in every state except IDLE.
REQ-012 Port turn SHALL be: output, 1 bit, one-cycle registered pulse on each direction reversal.
REQ-013 Port done SHALL be: output, 1 bit, one-cycle registered pulse on normal run completion.
REQ-014 Port err SHALL be: output, 1 bit, one-cycle registered pulse on a rejected start.

Function
REQ-015 The FSM SHALL have states IDLE, UP, DOWN; count, dir, turn, done and err are all registered.
REQ-016 In IDLE, start=1 with lo<hi and nsweep!=0 SHALL latch lo, hi and nsweep, load count=lo, set dir=1 and enter UP at the same edge.
REQ-017 In IDLE, start=1 with lo>=hi or nsweep==0 SHALL pulse err for one cycle, stay IDLE and leave count unchanged.
REQ-018 In UP with count<hi, count SHALL increment by 1 per clock.
REQ-019 In UP with count==hi, the block SHALL load count=hi-1, set dir=0, pulse turn and enter DOWN.
REQ-020 In DOWN with count>lo, count SHALL decrement by 1 per clock.
REQ-021 In DOWN with count==lo and remaining sweeps >1, the block SHALL decrement remaining sweeps, load count=lo+1, set dir=1, pulse turn and enter UP.
REQ-022 In DOWN with count==lo and remaining sweeps ==1, the block SHALL pulse done, hold count=lo, set dir=1 and enter IDLE.
REQ-023 Count SHALL never wrap: full range lo=0, hi=2^WIDTH-1 reverses at the limits with no overflow or underflow.
REQ-024 abort=1 in UP or DOWN SHALL enter IDLE at the next edge, freeze count, set dir=1 and suppress done and turn at that edge.
REQ-025 When abort=1 and start=1 together in IDLE, start SHALL be ignored and no err SHALL be raised.
REQ-026 start while busy SHALL be ignored; lo, hi and nsweep changes while busy SHALL have no effect.
REQ-027 Accepted start to first count change SHALL be 1 cycle; run length SHALL be nsweep*2*(hi-lo)+1 cycles of busy.

Reset
REQ-028 While reset=0: state=IDLE, count=0, dir=1, busy=0, turn=0, done=0, err=0, latched lo/hi/nsweep=0.
REQ-029 Reset asserted mid-run SHALL abandon the run with no done pulse; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-030 A shared package SHALL hold the state enumeration (IDLE, UP, DOWN) and the default WIDTH constant.
REQ-031 The counter register SHALL be a sub-module updown_core with inputs load, load_val, en, up; the sweep FSM drives it.

Verification
REQ-032 Reset low then high, no start -> count=0, busy=0, dir=1; no pulses on turn, done or err.
REQ-033 lo=2, hi=4, nsweep=1, start for 1 cycle -> count 2,3,4,3,2; turn once at 4->3; done one cycle; busy exactly 5 cycles.
REQ-034 lo=5, hi=5, start -> err pulse; also nsweep=0 with start -> err pulse; both leave busy=0 and count unchanged.
REQ-035 lo=0, hi=31, nsweep=2 -> no wrap past 31 or below 0; turn pulses 3 times; done after 125 busy cycles.
REQ-036 Run lo=1, hi=6, abort at count=4 rising -> IDLE next edge, count frozen at 4 or 5 per timing, no done; start+abort together -> ignored, no err.
REQ-037 Reset low mid-run at count=3 -> count=0 immediately without a clock edge; no done; a new start after release runs normally.
